ram_burst_controller: RTL

RAM_BURST_CONTROLLER -- requirements
Module: ram_burst_controller

---
 rtl/ram_burst_controller_if.sv | 47 ++++
 rtl/ram_burst_controller.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ram_burst_controller_if.sv
// ram_burst_controller_if
// Purpose : bundles the burst command, write/read streams and RAM port of the
//           burst controller.
// Signals : Start_i/Write_i/BaseAddress_i/Length_i - burst command
//           Busy_o/Done_o                          - burst status
//           WrData_i/WrValid_i/WrReady_o           - write stream (into RAM)
//           RdData_o/RdValid_o/RdReady_i           - read stream (out of RAM)
//           RamReadEnable_o/RamWriteEnable_o/RamAddress_o/RamData_o/RamData_i - RAM port
// Modports: slave  - the controller
//           master - the user / environment
interface ram_burst_controller_if #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned LENGTH_WIDTH  = 16
);
    logic                     Start_i;
    logic                     Write_i;
    logic [ADDRESS_WIDTH-1:0] BaseAddress_i;
    logic [LENGTH_WIDTH-1:0]  Length_i;
    logic                     Busy_o;
    logic                     Done_o;
    logic [DATA_WIDTH-1:0]    WrData_i;
    logic                     WrValid_i;
    logic                     WrReady_o;
    logic [DATA_WIDTH-1:0]    RdData_o;
    logic                     RdValid_o;
    logic                     RdReady_i;
    logic                     RamReadEnable_o;
    logic                     RamWriteEnable_o;
    logic [ADDRESS_WIDTH-1:0] RamAddress_o;
    logic [DATA_WIDTH-1:0]    RamData_o;
    logic [DATA_WIDTH-1:0]    RamData_i;

    modport slave (
        input  Start_i, Write_i, BaseAddress_i, Length_i,
        input  WrData_i, WrValid_i, RdReady_i, RamData_i,
        output Busy_o, Done_o, WrReady_o, RdData_o, RdValid_o,
        output RamReadEnable_o, RamWriteEnable_o, RamAddress_o, RamData_o
    );

    modport master (
        output Start_i, Write_i, BaseAddress_i, Length_i,
        output WrData_i, WrValid_i, RdReady_i, RamData_i,
        input  Busy_o, Done_o, WrReady_o, RdData_o, RdValid_o,
        input  RamReadEnable_o, RamWriteEnable_o, RamAddress_o, RamData_o
    );
endinterface

// File: rtl/ram_burst_controller.sv
// ram_burst_controller
// Purpose : moves a burst of Length_i words between a valid/ready stream and a
//           single-port RAM with a one-cycle registered read, starting at
//           BaseAddress_i and wrapping at the top of the address space.
// Ports   : Clock - rising-edge clock
//           Reset - synchronous active-high reset
//           bus   - ram_burst_controller_if.slave (command, streams, RAM port)
module ram_burst_controller #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned LENGTH_WIDTH  = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    ram_burst_controller_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] w_addr_next;
    logic [LENGTH_WIDTH-1:0]  r_remain;        // words still to write / read-issue
    logic [LENGTH_WIDTH-1:0]  w_remain_next;
    logic                     r_rd_valid;
    logic                     w_rd_valid_next;
    logic                     r_done;
    logic                     w_done_next;
    logic                     w_wr_beat;
    logic                     w_rd_issue;
    logic                     w_rd_accept;

    // State and counter registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_remain   <= w_remain_next;
            r_rd_valid <= w_rd_valid_next;
            r_done     <= w_done_next;
        end
    end

    // Next-state, counter update and RAM/stream strobes
    always_comb begin
        w_state_next         = r_state;
        w_addr_next          = r_addr;
        w_remain_next        = r_remain;
        w_rd_valid_next      = r_rd_valid;
        w_done_next          = 1'b0;
        w_wr_beat            = 1'b0;
        w_rd_issue           = 1'b0;
        w_rd_accept          = 1'b0;
        bus.WrReady_o        = 1'b0;
        bus.RamWriteEnable_o = 1'b0;
        bus.RamReadEnable_o  = 1'b0;
        bus.RamData_o        = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.Start_i) begin
                    if (bus.Length_i == '0) begin
                        // Empty burst: no RAM access, just acknowledge
                        w_done_next = 1'b1;
                    end else begin
                        w_addr_next   = bus.BaseAddress_i;
                        w_remain_next = bus.Length_i;
                        w_state_next  = bus.Write_i ? ST_WRITE : ST_READ;
                    end
                end
            end

            ST_WRITE: begin
                bus.WrReady_o = (r_remain != '0);
                w_wr_beat     = bus.WrReady_o && bus.WrValid_i;
                if (w_wr_beat) begin
                    bus.RamWriteEnable_o = 1'b1;
                    bus.RamData_o        = bus.WrData_i;
                    w_addr_next          = r_addr + ADDRESS_WIDTH'(1);
                    w_remain_next        = r_remain - LENGTH_WIDTH'(1);
                    if (r_remain == LENGTH_WIDTH'(1)) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end

            ST_READ: begin
                w_rd_accept = r_rd_valid && bus.RdReady_i;
                // The RAM output register is the only data buffer, so a new read
                // may only replace it when it is empty or being consumed now.
                w_rd_issue  = (r_remain != '0) && (!r_rd_valid || bus.RdReady_i);
                if (w_rd_issue) begin
                    bus.RamReadEnable_o = 1'b1;
                    w_addr_next         = r_addr + ADDRESS_WIDTH'(1);
                    w_remain_next       = r_remain - LENGTH_WIDTH'(1);
                end
                w_rd_valid_next = w_rd_issue || (r_rd_valid && !bus.RdReady_i);
                if ((r_remain == '0) && w_rd_accept) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end

            default: begin
                w_state_next    = ST_IDLE;
                w_rd_valid_next = 1'b0;
            end
        endcase
    end

    assign bus.Busy_o       = (r_state != ST_IDLE);
    assign bus.Done_o       = r_done;
    assign bus.RdValid_o    = r_rd_valid;
    assign bus.RdData_o     = bus.RamData_i;
    assign bus.RamAddress_o = r_addr;

endmodule
